// File: rtl/gpr_arbiter.sv
// gpr_arbiter: round-robin sharing of the single-port GPR file between
// the execute datapath (requester 0) and the I/O / debug port (requester 1).
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   req/we/addr/wdata0  requester 0 request bundle, held until ack0
//   ack0, rdata0        one-cycle completion pulse and read result
//   req/we/addr/wdata1  requester 1 request bundle, held until ack1
//   ack1, rdata1        one-cycle completion pulse and read result
//   gpr_addr/indata     registered GPR address and write data
//   gpr_read/write      registered GPR strobes, only ever high in ACCESS
//   gpr_outdata         GPR read data (high-Z unless gpr_read)
//   err0, err1          out-of-range flags, pulsed with ack (optional)
//
// Optional feature: define GPR_ARB_RANGE_CHECK_EN to add err0/err1 and
// suppress GPR access for addresses >= NUM_REGS.
module gpr_arbiter #(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
`ifdef GPR_ARB_RANGE_CHECK_EN
    output logic              err0,
    output logic              err1,
`endif
    output logic [ADDR_W-1:0] gpr_addr,
    output logic [DATA_W-1:0] gpr_indata,
    output logic              gpr_read,
    output logic              gpr_write,
    input  logic [DATA_W-1:0] gpr_outdata
);

    if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_cfg
        $error("gpr_arbiter: NUM_REGS does not fit ADDR_W");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched grant; gpr_addr / gpr_indata double as the latched
    // address and write data, so they need no separate copies.
    logic gnt_q, gnt_d;
    logic we_q, we_d;
    logic last_q, last_d;

    logic              read_d, write_d;
    logic              ack0_d, ack1_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] indata_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d;
    logic [DATA_W-1:0] cap;

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;

`ifdef GPR_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];
    logic ok_q, ok_d;
    logic err0_d, err1_d;
`endif

    // Winner in IDLE: a lone requester wins, a tie goes to the
    // requester that was not granted last.
    always_comb begin
        sel = req1;
        if (req0 && req1) begin
            sel = ~last_q;
        end
        sel_we    = sel ? we1    : we0;
        sel_addr  = sel ? addr1  : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
`ifdef GPR_ARB_RANGE_CHECK_EN
        sel_ok = ({1'b0, sel_addr} < NUM_REGS_W);
        cap    = ok_q ? gpr_outdata : '0;
`else
        sel_ok = 1'b1;
        cap    = gpr_outdata;
`endif
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        last_d   = last_q;
        addr_d   = gpr_addr;
        indata_d = gpr_indata;
        read_d   = 1'b0;
        write_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0;
        rdata1_d = rdata1;
`ifdef GPR_ARB_RANGE_CHECK_EN
        ok_d     = ok_q;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d  = ACCESS;
                    gnt_d    = sel;
                    we_d     = sel_we;
                    last_d   = sel;
                    addr_d   = sel_addr;
                    indata_d = sel_wdata;
                    // Strobes are registered, so they are set here to
                    // be high exactly during the ACCESS cycle.
                    read_d   = !sel_we && sel_ok;
                    write_d  = sel_we && sel_ok;
`ifdef GPR_ARB_RANGE_CHECK_EN
                    ok_d     = sel_ok;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                ack0_d  = !gnt_q;
                ack1_d  = gnt_q;
                if (!we_q) begin
                    if (gnt_q) begin
                        rdata1_d = cap;
                    end else begin
                        rdata0_d = cap;
                    end
                end
`ifdef GPR_ARB_RANGE_CHECK_EN
                err0_d = !gnt_q && !ok_q;
                err1_d = gnt_q && !ok_q;
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            last_q     <= 1'b1;
            gpr_addr   <= '0;
            gpr_indata <= '0;
            gpr_read   <= 1'b0;
            gpr_write  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
`ifdef GPR_ARB_RANGE_CHECK_EN
            ok_q       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            last_q     <= last_d;
            gpr_addr   <= addr_d;
            gpr_indata <= indata_d;
            gpr_read   <= read_d;
            gpr_write  <= write_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            rdata0     <= rdata0_d;
            rdata1     <= rdata1_d;
`ifdef GPR_ARB_RANGE_CHECK_EN
            ok_q       <= ok_d;
            err0       <= err0_d;
            err1       <= err1_d;
`endif
        end
    end

endmodule

// File: tb/tb_gpr_arbiter.sv
// tb_gpr_arbiter: randomized and directed bench for gpr_arbiter with a
// transaction-level reference model and a behavioural GPR file.
module tb_gpr_arbiter;

`ifdef GPR_ARB_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [9:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1;
    logic [9:0] rdata0, rdata1;
    logic [3:0] gpr_addr;
    logic [9:0] gpr_indata;
    logic       gpr_read, gpr_write;
`ifdef GPR_ARB_RANGE_CHECK_EN
    logic       err0, err1;
`endif

    logic [9:0] env_mem [16];
    wire  [9:0] gpr_outdata = gpr_read ? env_mem[gpr_addr] : 10'bz;

    gpr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .ack1        (ack1),
        .rdata1      (rdata1),
`ifdef GPR_ARB_RANGE_CHECK_EN
        .err0        (err0),
        .err1        (err1),
`endif
        .gpr_addr    (gpr_addr),
        .gpr_indata  (gpr_indata),
        .gpr_read    (gpr_read),
        .gpr_write   (gpr_write),
        .gpr_outdata (gpr_outdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) env_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (gpr_write) env_mem[gpr_addr] <= gpr_indata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each transaction is a grant, then one access
    // cycle, then one response cycle.
    int         m_phase = 0;
    bit         m_last = 1'b1;
    bit         t_id = 1'b0, t_we = 1'b0;
    logic [3:0] t_addr = '0;
    logic [9:0] t_data = '0;
    logic [9:0] m_rdata [2];
    logic [9:0] m_mem [16];

    initial begin
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end

    always @(posedge clk) begin
        bit inr, acc, rsp;
        inr = !RANGE || (t_addr < 4'd10);
        if (!rst) begin
            m_phase = 0;
            m_last = 1'b1;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                t_id   = (req0 && req1) ? !m_last : req1;
                t_we   = t_id ? we1 : we0;
                t_addr = t_id ? addr1 : addr0;
                t_data = t_id ? wdata1 : wdata0;
                m_last = t_id;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (t_we && inr) m_mem[t_addr] = t_data;
            if (!t_we) m_rdata[t_id] = inr ? m_mem[t_addr] : 10'd0;
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
        #1;
        inr = !RANGE || (t_addr < 4'd10);
        acc = (m_phase == 1);
        rsp = (m_phase == 2);
        chk("rw_excl", 32'(gpr_read & gpr_write), 0);
        chk("gpr_read", 32'(gpr_read), 32'(acc && !t_we && inr));
        chk("gpr_write", 32'(gpr_write), 32'(acc && t_we && inr));
        chk("ack0", 32'(ack0), 32'(rsp && !t_id));
        chk("ack1", 32'(ack1), 32'(rsp && t_id));
        chk("rdata0", 32'(rdata0), 32'(m_rdata[0]));
        chk("rdata1", 32'(rdata1), 32'(m_rdata[1]));
`ifdef GPR_ARB_RANGE_CHECK_EN
        chk("err0", 32'(err0), 32'(rsp && !t_id && !inr));
        chk("err1", 32'(err1), 32'(rsp && t_id && !inr));
`endif
        if (acc) begin
            chk("gpr_addr", 32'(gpr_addr), 32'(t_addr));
            if (t_we) chk("gpr_indata", 32'(gpr_indata), 32'(t_data));
        end
        if (!rst) begin
            chk("rst_addr", 32'(gpr_addr), 0);
            chk("rst_indata", 32'(gpr_indata), 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic new0();
        req0 = 1'b1;
        we0 = 1'($urandom_range(1));
        addr0 = 4'($urandom_range(15));
        wdata0 = 10'($urandom_range(1023));
    endtask

    task automatic new1();
        req1 = 1'b1;
        we1 = 1'($urandom_range(1));
        addr1 = 4'($urandom_range(15));
        wdata1 = 10'($urandom_range(1023));
    endtask

    task automatic drive_rand();
        if (req0 && ack0) begin
            if ($urandom_range(1) == 0) req0 = 1'b0;
            else new0();
        end else if (req0) begin
            if ($urandom_range(49) == 0) req0 = 1'b0;
        end else if ($urandom_range(9) < 4) begin
            new0();
        end
        if (req1 && ack1) begin
            if ($urandom_range(1) == 0) req1 = 1'b0;
            else new1();
        end else if (req1) begin
            if ($urandom_range(49) == 0) req1 = 1'b0;
        end else if ($urandom_range(9) < 4) begin
            new1();
        end
    endtask

    int ids[$];
    int at[$];

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ack0", 32'(ack0), 0);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_rd", 32'(gpr_read), 0);
        chk("rst_wr", 32'(gpr_write), 0);
        @(negedge clk);
        rst = 1'b1;

        // Requester 0 writes 0x155 to reg 3
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 10'h155;
        cyc();
        chk("t1_write", 32'(gpr_write), 1);
        chk("t1_addr", 32'(gpr_addr), 3);
        chk("t1_early_ack", 32'(ack0), 0);
        cyc();
        chk("t1_ack0", 32'(ack0), 1);
        chk("t1_wr_off", 32'(gpr_write), 0);
        @(negedge clk);
        req0 = 0;
        cyc();
        chk("t1_mem3", 32'(env_mem[3]), 32'h155);
        chk("t1_model3", 32'(m_mem[3]), 32'h155);

        // Requester 1 reads reg 3
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 4'd3;
        cyc();
        chk("t2_read", 32'(gpr_read), 1);
        cyc();
        chk("t2_ack1", 32'(ack1), 1);
        chk("t2_rdata1", 32'(rdata1), 32'h155);
        chk("t2_rdata0", 32'(rdata0), 0);
        chk("t2_rd_off", 32'(gpr_read), 0);
        @(negedge clk);
        req1 = 0;

        // Requester 1 writes; its rdata keeps the previous read
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 4'd7; wdata1 = 10'h0AB;
        cyc();
        cyc();
        chk("t3_ack1", 32'(ack1), 1);
        chk("t3_rdata1", 32'(rdata1), 32'h155);
        @(negedge clk);
        req1 = 0;
        cyc();
        chk("t3_mem7", 32'(env_mem[7]), 32'h0AB);

        // Both held high: grants alternate 0,1,0,1 every 3 cycles
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 4'd0;
        req1 = 1; we1 = 0; addr1 = 4'd1;
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (ack0) begin ids.push_back(0); at.push_back(c); end
            if (ack1) begin ids.push_back(1); at.push_back(c); end
            if (ids.size() >= 4) break;
        end
        @(negedge clk);
        req0 = 0; req1 = 0;
        chk("rr_count", 32'(ids.size()), 4);
        if (ids.size() >= 4) begin
            chk("rr_first_at", 32'(at[0]), 1);
            for (int i = 0; i < 4; i++) begin
                chk("rr_id", 32'(ids[i]), 32'(i % 2));
                if (i > 0) chk("rr_gap", 32'(at[i] - at[i-1]), 3);
            end
        end
        cyc();

        // Async reset during ACCESS of a write to reg 5
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 10'h2AA;
        cyc();
        chk("t5_write", 32'(gpr_write), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_wr_drop", 32'(gpr_write), 0);
        chk("t5_no_ack", 32'(ack0), 0);
        @(negedge clk);
        req0 = 0;
        cyc();
        chk("t5_no_ack2", 32'(ack0), 0);
        cyc();
        chk("t5_no_ack3", 32'(ack0), 0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk("t5_mem5", 32'(env_mem[5]), 0);

        // FSM restarts from IDLE: normal latency read of reg 3
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 4'd3;
        cyc();
        chk("t6_read", 32'(gpr_read), 1);
        cyc();
        chk("t6_ack0", 32'(ack0), 1);
        chk("t6_rdata0", 32'(rdata0), 32'h155);
        @(negedge clk);
        req0 = 0;
        cyc();

`ifdef GPR_ARB_RANGE_CHECK_EN
        // Out-of-range read of reg 12
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 4'd12;
        cyc();
        chk("t7_no_read", 32'(gpr_read), 0);
        cyc();
        chk("t7_ack0", 32'(ack0), 1);
        chk("t7_err0", 32'(err0), 1);
        chk("t7_rdata0", 32'(rdata0), 0);
        chk("t7_no_read2", 32'(gpr_read), 0);
        @(negedge clk);
        req0 = 0;
        cyc();
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive_rand();
        end
        @(negedge clk);
        req0 = 0; req1 = 0;
        repeat (5) cyc();
        for (int i = 0; i < 16; i++) begin
            chk("final_mem", 32'(env_mem[i]), 32'(m_mem[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
